hash_probe_engine: RTL and testbench

Parametrised second-generation tile-hash lookup for the Japanese-glyph path. It takes tile hashes over a valid/ready handshake and runs a configurable-depth Bloom pre-filter (1–4 probes, bypassable at run time). It then walks a chained hash table and returns the character code and translation pointer over a held valid/ready result port. Saturating statistics counters are included for dictionary tuning.

---
 rtl/hash_probe_pkg.sv | 73 +++++++
 rtl/hash_probe_stats.sv | 34 +++
 rtl/hash_probe_engine.sv | 253 +++++++++++++++++++++++++
 tb/tb_hash_probe_engine.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_probe_pkg.sv
// Shared types, constants and helpers for the tile-hash probe engine.
package hash_probe_pkg;

    // Widest hash the bloom_index helper can process.
    localparam int MAX_HASH_W = 64;

    // Default field widths of one dictionary entry {valid, tag, code, ptr}.
    localparam int DEF_HASH_W = 16;
    localparam int DEF_CODE_W = 8;
    localparam int DEF_PTR_W  = 16;

    // Statistics counter slots.
    localparam int NUM_STATS          = 4;
    localparam int STAT_LOOKUPS       = 0;
    localparam int STAT_HITS          = 1;
    localparam int STAT_BLOOM_REJECTS = 2;
    localparam int STAT_BLOOM_FP      = 3;

    // Per-probe salt byte, replicated across the hash width by salt_word().
    localparam logic [3:0][7:0] SALT_BYTES = {8'hC3, 8'h5A, 8'h00, 8'h00};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BLOOM_RD,
        ST_BLOOM_CHK,
        ST_CHAIN_RD,
        ST_CHAIN_CHK,
        ST_RESP
    } state_t;

    // Chain index width; a single-entry chain still carries one index bit.
    function automatic int chain_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of a packed dictionary entry {valid, tag, code, ptr}.
    function automatic int entry_w(input int hash_w, input int code_w, input int ptr_w);
        return 1 + hash_w + code_w + ptr_w;
    endfunction

    // Salt for probe k: its byte pattern repeated over hash_w bits.
    function automatic logic [MAX_HASH_W-1:0] salt_word(input logic [1:0] k, input int hash_w);
        logic [MAX_HASH_W-1:0] salt;
        logic [7:0]            pat;
        salt = '0;
        pat  = SALT_BYTES[k];
        for (int b = 0; b < MAX_HASH_W; b++) begin
            if (b < hash_w) begin
                salt[6'(b)] = pat[3'(b)];
            end
        end
        return salt;
    endfunction

    // Bloom probe address before truncation: rotl(hash, 8k mod hash_w) ^ salt_k.
    function automatic logic [MAX_HASH_W-1:0] bloom_index(input logic [MAX_HASH_W-1:0] hash,
                                                          input int hash_w,
                                                          input logic [1:0] k);
        logic [MAX_HASH_W-1:0] rot;
        logic [5:0]            idx;
        int                    sh;
        rot = '0;
        sh  = (8 * int'(k)) % hash_w;
        for (int b = 0; b < MAX_HASH_W; b++) begin
            if (b < hash_w) begin
                idx      = 6'((b + sh) % hash_w);
                rot[idx] = hash[6'(b)];
            end
        end
        return rot ^ salt_word(k, hash_w);
    endfunction

endpackage

// File: rtl/hash_probe_stats.sv
// Saturating statistics counters with a shared synchronous clear.
module hash_probe_stats
    import hash_probe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic [NUM_STATS-1:0]             inc,
    output logic [NUM_STATS-1:0][CNT_W-1:0]  cnt
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STATS; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;

            // Count up on strobe, stick at all-ones; clear overrides the strobe.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (clr) begin
                    r_cnt <= '0;
                end else if (inc[gi] && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign cnt[gi] = r_cnt;
        end
    endgenerate

endmodule

// File: rtl/hash_probe_engine.sv
// Tile-hash lookup: optional Bloom pre-filter followed by a chained hash-table walk.
module hash_probe_engine
    import hash_probe_pkg::*;
#(
    parameter int HASH_W         = 16,
    parameter int BUCKET_BITS    = 12,
    parameter int CHAIN_DEPTH    = 4,
    parameter int BLOOM_ADDR_W   = 16,
    parameter int NUM_BLOOM_HASH = 3,
    parameter int CODE_W         = 8,
    parameter int PTR_W          = 16,
    parameter int CNT_W          = 32
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           cfg_bloom_en,
    input  logic                                           req_valid,
    output logic                                           req_ready,
    input  logic [HASH_W-1:0]                              req_hash,
    output logic                                           res_valid,
    input  logic                                           res_ready,
    output logic                                           res_hit,
    output logic [CODE_W-1:0]                              res_code,
    output logic [PTR_W-1:0]                               res_ptr,
    input  logic                                           dict_wr_en,
    input  logic [BUCKET_BITS+chain_bits(CHAIN_DEPTH)-1:0] dict_wr_addr,
    input  logic [entry_w(HASH_W, CODE_W, PTR_W)-1:0]      dict_wr_data,
    input  logic                                           bloom_wr_en,
    input  logic [BLOOM_ADDR_W-1:0]                        bloom_wr_addr,
    input  logic                                           bloom_wr_bit,
    input  logic                                           stats_clr,
    output logic [CNT_W-1:0]                               stat_lookups,
    output logic [CNT_W-1:0]                               stat_hits,
    output logic [CNT_W-1:0]                               stat_bloom_rejects,
    output logic [CNT_W-1:0]                               stat_bloom_fp
);

    localparam int CHAIN_BITS  = chain_bits(CHAIN_DEPTH);
    localparam int DICT_AW     = BUCKET_BITS + CHAIN_BITS;
    localparam int ENTRY_W     = entry_w(HASH_W, CODE_W, PTR_W);
    localparam int DICT_DEPTH  = 1 << DICT_AW;
    localparam int BLOOM_DEPTH = 1 << BLOOM_ADDR_W;

    localparam logic [1:0]            LAST_K = 2'(NUM_BLOOM_HASH - 1);
    localparam logic [CHAIN_BITS-1:0] LAST_I = CHAIN_BITS'(CHAIN_DEPTH - 1);

    // FSM and lookup context
    state_t                r_state;
    state_t                w_state_next;
    logic                  r_req_ready;
    logic [HASH_W-1:0]     r_hash;
    logic                  r_bloom_en;
    logic [1:0]            r_k;
    logic [CHAIN_BITS-1:0] r_i;
    logic                  r_hit;
    logic [CODE_W-1:0]     r_code;
    logic [PTR_W-1:0]      r_ptr;

    // Result port registers
    logic                  r_res_valid;
    logic                  r_res_hit;
    logic [CODE_W-1:0]     r_res_code;
    logic [PTR_W-1:0]      r_res_ptr;

    // Memories and their registered read data
    logic                  r_bloom_mem [BLOOM_DEPTH];
    logic [ENTRY_W-1:0]    r_dict_mem  [DICT_DEPTH];
    logic                  r_bloom_bit;
    logic [ENTRY_W-1:0]    r_dict_rd;

    logic [BLOOM_ADDR_W-1:0] w_bloom_addr;
    logic [DICT_AW-1:0]      w_dict_addr;
    logic                    w_accept;
    logic                    w_ent_valid;
    logic [HASH_W-1:0]       w_ent_tag;
    logic [CODE_W-1:0]       w_ent_code;
    logic [PTR_W-1:0]        w_ent_ptr;
    logic                    w_match;
    logic [NUM_STATS-1:0]    w_inc;
    logic [NUM_STATS-1:0][CNT_W-1:0] w_cnt;

    assign w_accept     = req_valid && r_req_ready;
    assign w_bloom_addr = BLOOM_ADDR_W'(bloom_index(MAX_HASH_W'(r_hash), HASH_W, r_k));
    assign w_dict_addr  = {r_hash[BUCKET_BITS-1:0], r_i};

    assign w_ent_valid = r_dict_rd[ENTRY_W-1];
    assign w_ent_tag   = r_dict_rd[ENTRY_W-2 -: HASH_W];
    assign w_ent_code  = r_dict_rd[CODE_W+PTR_W-1 -: CODE_W];
    assign w_ent_ptr   = r_dict_rd[PTR_W-1:0];
    assign w_match     = w_ent_valid && (w_ent_tag == r_hash);

    // Bloom bit array: write port plus an always-on read-first registered read.
    always_ff @(posedge clk) begin
        if (bloom_wr_en) begin
            r_bloom_mem[bloom_wr_addr] <= bloom_wr_bit;
        end
        r_bloom_bit <= r_bloom_mem[w_bloom_addr];
    end

    // Chained dictionary: write port plus an always-on read-first registered read.
    always_ff @(posedge clk) begin
        if (dict_wr_en) begin
            r_dict_mem[dict_wr_addr] <= dict_wr_data;
        end
        r_dict_rd <= r_dict_mem[w_dict_addr];
    end

    // State register; req_ready is registered so it stays low while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_req_ready <= (w_state_next == ST_IDLE);
        end
    end

    // Next-state decode and statistics strobes.
    always_comb begin
        w_state_next = r_state;
        w_inc        = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = cfg_bloom_en ? ST_BLOOM_RD : ST_CHAIN_RD;
                end
            end
            ST_BLOOM_RD: begin
                w_state_next = ST_BLOOM_CHK;
            end
            ST_BLOOM_CHK: begin
                if (!r_bloom_bit) begin
                    w_state_next              = ST_RESP;
                    w_inc[STAT_BLOOM_REJECTS] = 1'b1;
                end else if (r_k == LAST_K) begin
                    w_state_next = ST_CHAIN_RD;
                end else begin
                    w_state_next = ST_BLOOM_RD;
                end
            end
            ST_CHAIN_RD: begin
                w_state_next = ST_CHAIN_CHK;
            end
            ST_CHAIN_CHK: begin
                if (w_match) begin
                    w_state_next = ST_RESP;
                end else if (!w_ent_valid || (r_i == LAST_I)) begin
                    w_state_next         = ST_RESP;
                    w_inc[STAT_BLOOM_FP] = r_bloom_en;
                end else begin
                    w_state_next = ST_CHAIN_RD;
                end
            end
            ST_RESP: begin
                if (r_res_valid && res_ready) begin
                    w_state_next        = ST_IDLE;
                    w_inc[STAT_LOOKUPS] = 1'b1;
                    w_inc[STAT_HITS]    = r_res_hit;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Lookup context: latch request, step probe/chain indices, capture a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hash     <= '0;
            r_bloom_en <= 1'b0;
            r_k        <= '0;
            r_i        <= '0;
            r_hit      <= 1'b0;
            r_code     <= '0;
            r_ptr      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_hash     <= req_hash;
                        r_bloom_en <= cfg_bloom_en;
                        r_k        <= '0;
                        r_i        <= '0;
                        r_hit      <= 1'b0;
                        r_code     <= '0;
                        r_ptr      <= '0;
                    end
                end
                ST_BLOOM_CHK: begin
                    if (r_bloom_bit && (r_k != LAST_K)) begin
                        r_k <= r_k + 2'd1;
                    end
                end
                ST_CHAIN_CHK: begin
                    if (w_match) begin
                        r_hit  <= 1'b1;
                        r_code <= w_ent_code;
                        r_ptr  <= w_ent_ptr;
                    end else if (w_ent_valid && (r_i != LAST_I)) begin
                        r_i <= r_i + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result port: publish one cycle after entering RESP, hold until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_hit   <= 1'b0;
            r_res_code  <= '0;
            r_res_ptr   <= '0;
        end else if (r_state == ST_RESP) begin
            if (!r_res_valid) begin
                r_res_valid <= 1'b1;
                r_res_hit   <= r_hit;
                r_res_code  <= r_code;
                r_res_ptr   <= r_ptr;
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
                r_res_hit   <= 1'b0;
                r_res_code  <= '0;
                r_res_ptr   <= '0;
            end
        end
    end

    hash_probe_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stats_clr),
        .inc   (w_inc),
        .cnt   (w_cnt)
    );

    assign req_ready          = r_req_ready;
    assign res_valid          = r_res_valid;
    assign res_hit            = r_res_hit;
    assign res_code           = r_res_code;
    assign res_ptr            = r_res_ptr;
    assign stat_lookups       = w_cnt[STAT_LOOKUPS];
    assign stat_hits          = w_cnt[STAT_HITS];
    assign stat_bloom_rejects = w_cnt[STAT_BLOOM_REJECTS];
    assign stat_bloom_fp      = w_cnt[STAT_BLOOM_FP];

endmodule

// File: tb/tb_hash_probe_engine.sv
// Directed bench for hash_probe_engine with default parameters.
module tb_hash_probe_engine;

    logic        clk;
    logic        rst_n;
    logic        cfg_bloom_en;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_hash;
    logic        res_valid;
    logic        res_ready;
    logic        res_hit;
    logic [7:0]  res_code;
    logic [15:0] res_ptr;
    logic        dict_wr_en;
    logic [13:0] dict_wr_addr;
    logic [40:0] dict_wr_data;
    logic        bloom_wr_en;
    logic [15:0] bloom_wr_addr;
    logic        bloom_wr_bit;
    logic        stats_clr;
    logic [31:0] stat_lookups;
    logic [31:0] stat_hits;
    logic [31:0] stat_bloom_rejects;
    logic [31:0] stat_bloom_fp;

    int n_pass  = 0;
    int n_total = 0;

    hash_probe_engine dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cfg_bloom_en       (cfg_bloom_en),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_hash           (req_hash),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_hit            (res_hit),
        .res_code           (res_code),
        .res_ptr            (res_ptr),
        .dict_wr_en         (dict_wr_en),
        .dict_wr_addr       (dict_wr_addr),
        .dict_wr_data       (dict_wr_data),
        .bloom_wr_en        (bloom_wr_en),
        .bloom_wr_addr      (bloom_wr_addr),
        .bloom_wr_bit       (bloom_wr_bit),
        .stats_clr          (stats_clr),
        .stat_lookups       (stat_lookups),
        .stat_hits          (stat_hits),
        .stat_bloom_rejects (stat_bloom_rejects),
        .stat_bloom_fp      (stat_bloom_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic bloom_write(input logic [15:0] addr, input logic bit_val);
        @(negedge clk);
        bloom_wr_en   = 1'b1;
        bloom_wr_addr = addr;
        bloom_wr_bit  = bit_val;
        @(negedge clk);
        bloom_wr_en   = 1'b0;
    endtask

    task automatic dict_write(input logic [1:0] slot, input logic v, input logic [15:0] tag,
                              input logic [7:0] code, input logic [15:0] ptr);
        @(negedge clk);
        dict_wr_en   = 1'b1;
        dict_wr_addr = {12'h234, slot};
        dict_wr_data = {v, tag, code, ptr};
        @(negedge clk);
        dict_wr_en   = 1'b0;
    endtask

    task automatic check_stats(input string tag, input int lk, input int ht, input int rj, input int fp);
        chk({tag, "_lookups"}, 64'(stat_lookups), 64'(lk));
        chk({tag, "_hits"}, 64'(stat_hits), 64'(ht));
        chk({tag, "_rejects"}, 64'(stat_bloom_rejects), 64'(rj));
        chk({tag, "_fp"}, 64'(stat_bloom_fp), 64'(fp));
    endtask

    // One lookup: accept at edge 0, measure the res_valid edge, check the result,
    // optionally hold res_ready low, then consume (optionally with stats_clr).
    task automatic lookup(input string tag, input logic [15:0] h, input logic bloom,
                          input int exp_edge, input logic exp_hit, input logic [7:0] exp_code,
                          input logic [15:0] exp_ptr, input int hold, input logic clr);
        int lat;
        logic [7:0] held_code;
        @(negedge clk);
        chk({tag, "_req_ready_pre"}, 64'(req_ready), 64'd1);
        req_valid    = 1'b1;
        req_hash     = h;
        cfg_bloom_en = bloom;
        @(posedge clk);
        @(negedge clk);
        req_valid    = 1'b0;
        req_hash     = 16'h0;
        cfg_bloom_en = ~bloom;
        chk({tag, "_req_ready_busy"}, 64'(req_ready), 64'd0);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (res_valid) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_edge));
        chk({tag, "_hit"}, 64'(res_hit), 64'(exp_hit));
        chk({tag, "_code"}, 64'(res_code), 64'(exp_code));
        chk({tag, "_ptr"}, 64'(res_ptr), 64'(exp_ptr));
        held_code = exp_code;
        for (int c = 0; c < hold; c++) begin
            req_valid = 1'b1;
            req_hash  = 16'h5555;
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
            chk({tag, "_hold_code"}, 64'(res_code), 64'(held_code));
            chk({tag, "_hold_req_ready"}, 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        stats_clr = clr;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        stats_clr = 1'b0;
        chk({tag, "_req_ready_post"}, 64'(req_ready), 64'd1);
        chk({tag, "_res_valid_post"}, 64'(res_valid), 64'd0);
        $display("lookup %s hash=%h bloom=%0d edge=%0d hit=%0d code=%h", tag, h, bloom, lat, exp_hit, exp_code);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        cfg_bloom_en  = 1'b1;
        req_valid     = 1'b0;
        req_hash      = '0;
        res_ready     = 1'b0;
        dict_wr_en    = 1'b0;
        dict_wr_addr  = '0;
        dict_wr_data  = '0;
        bloom_wr_en   = 1'b0;
        bloom_wr_addr = '0;
        bloom_wr_bit  = 1'b0;
        stats_clr     = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_hit", 64'(res_hit), 64'd0);
        chk("rst_res_code", 64'(res_code), 64'd0);
        chk("rst_res_ptr", 64'(res_ptr), 64'd0);
        check_stats("rst", 0, 0, 0, 0);
        rst_n = 1'b1;

        // Bloom bits for 0x1234 and its entry in slot {0x234, 0}.
        bloom_write(16'h1234, 1'b1);
        bloom_write(16'h3412, 1'b1);
        bloom_write(16'h486E, 1'b1);
        dict_write(2'd0, 1'b1, 16'h1234, 8'h41, 16'hBEEF);
        lookup("bloom_hit", 16'h1234, 1'b1, 9, 1'b1, 8'h41, 16'hBEEF, 0, 1'b0);
        check_stats("s1", 1, 1, 0, 0);

        // First probe bit cleared: reject after one probe.
        bloom_write(16'h1234, 1'b0);
        lookup("bloom_reject", 16'h1234, 1'b1, 3, 1'b0, 8'h00, 16'h0000, 0, 1'b0);
        check_stats("s2", 2, 1, 1, 0);

        // Filter passes; match in the last chain slot.
        bloom_write(16'h1234, 1'b1);
        dict_write(2'd0, 1'b1, 16'hA234, 8'h11, 16'h1111);
        dict_write(2'd1, 1'b1, 16'hB234, 8'h22, 16'h2222);
        dict_write(2'd2, 1'b1, 16'hC234, 8'h33, 16'h3333);
        dict_write(2'd3, 1'b1, 16'h1234, 8'h44, 16'h0444);
        lookup("chain_last_hit", 16'h1234, 1'b1, 15, 1'b1, 8'h44, 16'h0444, 0, 1'b0);

        // Full chain of mismatches after a passed filter: false positive.
        dict_write(2'd3, 1'b1, 16'hD234, 8'h55, 16'h5555);
        lookup("chain_full_miss", 16'h1234, 1'b1, 15, 1'b0, 8'h00, 16'h0000, 0, 1'b0);
        check_stats("s4", 4, 2, 1, 1);

        // Bypassed filter: slot 0 mismatch, slot 1 invalid ends the walk.
        dict_write(2'd1, 1'b0, 16'h1234, 8'h66, 16'h6666);
        lookup("bypass_miss", 16'h1234, 1'b0, 5, 1'b0, 8'h00, 16'h0000, 0, 1'b0);
        check_stats("s5", 5, 2, 1, 1);

        // Held result: outputs stable and new requests ignored for 10 cycles.
        dict_write(2'd0, 1'b1, 16'h1234, 8'h41, 16'hBEEF);
        lookup("hold_hit", 16'h1234, 1'b0, 3, 1'b1, 8'h41, 16'hBEEF, 10, 1'b0);
        check_stats("s6", 6, 3, 1, 1);

        // Asynchronous reset while the engine sits in CHAIN_CHK.
        @(negedge clk);
        req_valid    = 1'b1;
        req_hash     = 16'h1234;
        cfg_bloom_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_res_valid", 64'(res_valid), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        chk("midrst_res_code", 64'(res_code), 64'd0);
        check_stats("midrst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset asserted during chain check");

        // Table contents survive reset; counters restart from zero.
        lookup("post_rst_hit", 16'h1234, 1'b0, 3, 1'b1, 8'h41, 16'hBEEF, 0, 1'b0);
        check_stats("s7", 1, 1, 0, 0);

        // Clear coincident with a hit exit wins over the increment.
        lookup("clr_on_exit", 16'h1234, 1'b0, 3, 1'b1, 8'h41, 16'hBEEF, 0, 1'b1);
        check_stats("s8", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
